// File: rtl/srt4_div_ctrl.sv
// srt4_div_ctrl: control sequencer for the radix-4 SRT divider datapath.
// It generates the operand mux selects, the staging-register load strobes and
// the quotient shift/finalise strobes. It counts quotient digits,
// short-circuits divide-by-zero, and pulses done for one cycle at the end.
// Every output is decoded from registered state only, so start, abort and
// dzero have no combinational path to any output.
module srt4_div_ctrl #(
    parameter int NUM_DIGITS = 13,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic             dzero,
    output logic             loadR,
    output logic             loadD,
    output logic             loadRreg27,
    output logic             loadDreg27,
    output logic             shiftq,
    output logic             doneq,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] digit_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_FINISH,
        S_DONE
    } state_t;

    // Index of the final digit; ITER leaves for FINISH when the count reaches it.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

    state_t           state_q, state_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] digit_cnt_q, digit_cnt_d;

    // State, error flag and digit counter registers, cleared by the async reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            err_q       <= 1'b0;
            digit_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            digit_cnt_q <= digit_cnt_d;
        end
    end

    // Next-state logic: sequence the digit count, with abort overriding everything.
    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        digit_cnt_d = digit_cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d     = S_IDLE;
                digit_cnt_d = '0;
                if (start) begin
                    if (dzero) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                        err_d   = 1'b0;
                    end
                end
            end
            S_LOAD: begin
                state_d     = S_ITER;
                digit_cnt_d = CNT_W'(1);
            end
            S_ITER: begin
                if (digit_cnt_q == LAST_CNT) begin
                    state_d     = S_FINISH;
                    digit_cnt_d = '0;
                end else begin
                    digit_cnt_d = digit_cnt_q + CNT_W'(1);
                end
            end
            S_FINISH: begin
                state_d = S_DONE;
            end
            default: begin
                state_d     = S_IDLE;
                digit_cnt_d = '0;
            end
        endcase
        if (abort && (state_q == S_LOAD || state_q == S_ITER || state_q == S_FINISH)) begin
            state_d     = S_IDLE;
            digit_cnt_d = '0;
        end
    end

    // Output decode from the registered state. In ITER the R staging register
    // still reloads every cycle, taking the fed-back partial remainder.
    always_comb begin
        loadR      = 1'b0;
        loadD      = 1'b0;
        loadRreg27 = 1'b0;
        loadDreg27 = 1'b0;
        shiftq     = 1'b0;
        doneq      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = err_q;
        digit_cnt  = digit_cnt_q;
        case (state_q)
            S_LOAD: begin
                loadR      = 1'b1;
                loadD      = 1'b1;
                loadRreg27 = 1'b1;
                loadDreg27 = 1'b1;
                shiftq     = 1'b1;
                busy       = 1'b1;
            end
            S_ITER: begin
                loadD      = 1'b1;
                loadRreg27 = 1'b1;
                shiftq     = 1'b1;
                busy       = 1'b1;
            end
            S_FINISH: begin
                loadD = 1'b1;
                doneq = 1'b1;
                busy  = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
